// File: rtl/seg7_pkg.sv
// Shared 7-segment codes (active-low, gfedcba), digit lookup and controller state type.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_OFF   = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_ONE   = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_TWO   = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_THREE = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_FOUR  = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_FIVE  = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_SIX   = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_SEVEN = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_EIGHT = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_NINE  = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_M     = 7'b1101010;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_X     = 7'b0001001;
  localparam logic [SEG_W-1:0] SEG_PERC1 = 7'b0011100;
  localparam logic [SEG_W-1:0] SEG_PERC2 = 7'b0100011;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    LOAD,
    DIV,
    BCD,
    SHOW,
    DONE
  } state_t;

  function automatic logic [SEG_W-1:0] seg_code(input logic [3:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = SEG_ZERO;
      4'd1:    s = SEG_ONE;
      4'd2:    s = SEG_TWO;
      4'd3:    s = SEG_THREE;
      4'd4:    s = SEG_FOUR;
      4'd5:    s = SEG_FIVE;
      4'd6:    s = SEG_SIX;
      4'd7:    s = SEG_SEVEN;
      4'd8:    s = SEG_EIGHT;
      4'd9:    s = SEG_NINE;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle for NUM_W cycles after a start pulse.
// done_c/quotient_c flag the final step and carry the quotient being committed on it.
module seq_divider #(
  parameter int unsigned NUM_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [NUM_W-1:0] dividend,
  input  logic [NUM_W-1:0] divisor,
  output logic             done_c,
  output logic [NUM_W-1:0] quotient_c
);

  localparam int unsigned BIT_W = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] rem_q, quo_q, rem_d, quo_d;
  logic [BIT_W-1:0] bits_q;
  logic             run_q;
  logic [NUM_W:0]   trial;

  // One restoring step: shift in the next dividend bit and try to subtract.
  always_comb begin
    trial = {rem_q, quo_q[NUM_W-1]};
    rem_d = trial[NUM_W-1:0];
    quo_d = {quo_q[NUM_W-2:0], 1'b0};
    if (trial >= {1'b0, divisor}) begin
      rem_d    = NUM_W'(trial - {1'b0, divisor});
      quo_d[0] = 1'b1;
    end
  end

  assign done_c     = run_q && (bits_q == BIT_W'(1));
  assign quotient_c = quo_d;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rem_q  <= '0;
      quo_q  <= '0;
      bits_q <= '0;
      run_q  <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      bits_q <= BIT_W'(NUM_W);
      run_q  <= 1'b1;
    end else if (run_q) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      bits_q <= bits_q - BIT_W'(1);
      run_q  <= (bits_q != BIT_W'(1));
    end
  end

endmodule

// File: rtl/progress_display_ctrl.sv
// Counts cell_done pulses, converts count*100/(N*N) to a percent and drives two 7-seg digits.
// Optional build macro PROGRESS_BLANK_LEAD_EN blanks the tens digit below 10 %.
module progress_display_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned N     = 5,
  parameter int unsigned CNT_W = $clog2(N*N + 1),
  parameter int unsigned NUM_W = $clog2(N*N*100 + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       clear,
  input  logic       cell_done,
  output logic [6:0] digit1,
  output logic [6:0] digit2,
  output logic [6:0] pct,
  output logic       busy
);

  localparam int unsigned TOTAL = N * N;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             pending_q;
  logic [6:0]       work_q, units_q;
  logic [3:0]       tens_q;
  logic             div_start, div_done_c;
  logic [NUM_W-1:0] div_quo_c;
  logic             counting;

  seq_divider #(.NUM_W(NUM_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (div_start),
    .flush      (start || clear),
    .dividend   (NUM_W'(32'(count_q) * 32'd100)),
    .divisor    (NUM_W'(TOTAL)),
    .done_c     (div_done_c),
    .quotient_c (div_quo_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; clear beats start, start abandons any conversion in flight.
  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    if (clear) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = WAIT;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        WAIT: if (pending_q) state_d = LOAD;
        LOAD: begin
          div_start = 1'b1;
          state_d   = DIV;
        end
        DIV:  if (div_done_c) state_d = BCD;
        BCD:  if (units_q < 7'd10) state_d = SHOW;
        SHOW: state_d = (work_q == 7'd100) ? DONE : WAIT;
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign counting = cell_done && (state_q != IDLE) && (state_q != DONE);

  // Cell counter and pending flag; a pulse in the LOAD cycle keeps pending set.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q   <= '0;
      pending_q <= 1'b0;
    end else if (start) begin
      count_q   <= '0;
      pending_q <= 1'b1;
    end else begin
      if (state_q == LOAD) pending_q <= 1'b0;
      if (counting) begin
        if (count_q != CNT_W'(TOTAL)) count_q <= count_q + CNT_W'(1);
        pending_q <= 1'b1;
      end
    end
  end

  // BCD split and display registers; both digits and pct commit in SHOW only.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q  <= '0;
      units_q <= '0;
      tens_q  <= '0;
      digit1  <= SEG_DASH;
      digit2  <= SEG_DASH;
      pct     <= '0;
      busy    <= 1'b0;
    end else begin
      busy <= (state_d inside {LOAD, DIV, BCD, SHOW});
      if (clear) begin
        digit1 <= SEG_DASH;
        digit2 <= SEG_DASH;
        pct    <= '0;
      end else if (!start) begin
        case (state_q)
          DIV: if (div_done_c) begin
            work_q  <= 7'(div_quo_c);
            units_q <= 7'(div_quo_c);
            tens_q  <= '0;
          end
          BCD: if (units_q >= 7'd10) begin
            units_q <= units_q - 7'd10;
            tens_q  <= tens_q + 4'd1;
          end
          SHOW: begin
            pct <= work_q;
            if (work_q == 7'd100) begin
              digit1 <= SEG_M;
              digit2 <= SEG_A;
            end else begin
`ifdef PROGRESS_BLANK_LEAD_EN
              digit1 <= (tens_q == 4'd0) ? SEG_OFF : seg_code(tens_q);
`else
              digit1 <= seg_code(tens_q);
`endif
              digit2 <= seg_code(4'(units_q));
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/progress_display_ctrl.md
Name: progress_display_ctrl

Overview:
- Sequences the 4-digit 7-segment display driver during an alignment run.
- Counts matrix-cell completion pulses from the scoring engine and computes progress = floor(count*100/(N*N)) with a sequential divider.
- Converts the result to two 7-segment codes: digit1 is tens, digit2 is units.
- Presents dashes when idle and the M/A pair at 100 %, which the driver renders as "MAX".

Parameters:
- N, 5, sequence length; TOTAL = N*N matrix cells.
- CNT_W, $clog2(N*N+1), width of the cell counter.
- NUM_W, $clog2(N*N*100+1), numerator and divider width (12 for N=5).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; clears the counter and begins a run.
- clear  in  1  one-cycle pulse; aborts and returns to idle (dashes).
- cell_done  in  1  one-cycle pulse per computed matrix cell.
- digit1  out  7  tens code to the display driver (active-low segments, gfedcba).
- digit2  out  7  units code to the display driver.
- pct  out  7  binary percent currently displayed, 0..100.
- busy  out  1  high while a conversion (LOAD..SHOW) is in progress.

Behaviour:
- Reset values: digit1 = digit2 = DASH (0111111), pct = 0, busy = 0, count = 0, pending = 0, state = IDLE.
- Segment constants: ZERO..NINE, DASH, M = 1101010, A = 0001000, OFF = 1111111.
- FSM states:
  - IDLE: outputs dashes; cell_done ignored. start → count = 0, pending = 1 → WAIT.
  - WAIT: idle within a run. pending → LOAD.
  - LOAD: snapshot = count, pending = 0; numerator = snapshot*100 (NUM_W bits). 1 cycle → DIV.
  - DIV: restoring division by TOTAL, one quotient bit per cycle, exactly NUM_W cycles; quotient in 0..100 → BCD.
  - BCD: if remainder-of-quotient ≥ 10, subtract 10 and increment tens (1 cycle each); otherwise → SHOW.
  - SHOW: registers digit1/digit2/pct together in one cycle, so digits never tear. If quotient == 100 → DONE, else → WAIT.
  - DONE: outputs digit1 = M, digit2 = A, pct = 100; cell_done ignored. start restarts; clear → IDLE.
- Counter:
  - Increments on cell_done in every state except IDLE and DONE.
  - Saturates at TOTAL.
  - Every accepted pulse sets pending.
- Pulses arriving during LOAD..SHOW are counted, and pending stays set. Exactly one further conversion follows and uses the latest count; no pulse is lost.
- Latency from an isolated cell_done to the digits updating: 1 (count) + 1 (WAIT) + 1 (LOAD) + NUM_W (DIV) + tens (BCD steps) + 1 (BCD exit) + 1 (SHOW).
- For N=5 and 12 %: 1+1+1+12+1+1+1 = 18 cycles.
- busy is high exactly during LOAD, DIV, BCD and SHOW.
- start during any state: counter = 0, pending = 1, any division in flight is abandoned → WAIT. Digits hold their previous values until the next SHOW.
- clear has priority over start and cell_done in the same cycle. It forces IDLE with dashes, pct = 0, count = 0, pending = 0.
- start together with cell_done: start wins; the count becomes 0, not 1.
- rst mid-division: all registers return to their reset values on the next edge.

Optional Feature:
- Macro: PROGRESS_BLANK_LEAD_EN.
- Defined: when pct < 10, digit1 = OFF (leading zero blanked).
- Undefined: digit1 = ZERO for pct < 10.
- DONE and IDLE encodings are unaffected either way.

Decomposition:
- Package seg7_pkg holds:
  - the segment constants (OFF, ZERO..NINE, M, A, X, PERC1, PERC2, DASH);
  - a function mapping 0..9 to its segment code;
  - the state enum typedef.
- Sub-module seq_divider: a restoring divider with start/done handshake, parameterised on NUM_W, instantiated once with divisor TOTAL.

Test Plan:
- After reset with no stimulus for 100 cycles → digit1 = digit2 = DASH, pct = 0, busy = 0.
- start, wait 20 cycles → digit1 = ZERO, digit2 = ZERO, pct = 0 (with the macro defined, digit1 = OFF).
- N=5: start, then 3 isolated cell_done pulses, each followed by 20 idle cycles:
  - after pulse 1: pct = 4, digits ZERO/FOUR;
  - after pulse 3: pct = 12, digits ONE/TWO;
  - the pulse-3 update lands exactly 18 cycles after the pulse.
- 5 back-to-back cell_done pulses → exactly one or two conversions; the final pct = 20 (TWO/ZERO), with no intermediate torn digit pair.
- 30 cell_done pulses after start → count saturates at 25; digit1 = M, digit2 = A, pct = 100; extra pulses do nothing.
- clear asserted during DIV, and start together with cell_done → dashes within 1 cycle; the restart shows pct = 0, not 4.
